// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: timer register map, control bits and scheduler FSM encoding
package timer_sched_pkg;
  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam logic [15:0] CMD_STOP  = 16'(1) << CTRL_STOP;
  localparam logic [15:0] CMD_START = (16'(1) << CTRL_ITO) | (16'(1) << CTRL_START);
  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_PERL, WR_PERH, WR_CLR0, WR_START, WAIT_IRQ, WR_CLR1, WR_HALT, DONE
  } state_t;
  function automatic logic is_wr(state_t s);
    return s inside {WR_STOP, WR_PERL, WR_PERH, WR_CLR0, WR_START, WR_CLR1, WR_HALT};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot selector; search starts after the last winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] winner
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr;
  logic [W-1:0] win_idx;
  always_comb begin
    winner  = '0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        winner = '0;
        winner[(int'(ptr) + k) % N] = 1'b1;
        win_idx = W'((int'(ptr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (advance && |req) ptr <= (win_idx == W'(N - 1)) ? '0 : win_idx + 1'b1;
  end
endmodule

// File: rtl/timer_req_scheduler.sv
// timer_req_scheduler: shares one interval timer among requesters, programming it per grant
module timer_req_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MIN_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  delay,
  input  logic [NUM_REQ-1:0]     abort,
  output logic [NUM_REQ-1:0]     done,
  output logic                   aborted,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);
  state_t state, state_n;
  logic [31:0] period, sel_delay, clamped;
  logic ab_flag, ab_n, start, abort_g;
  logic [NUM_REQ-1:0] winner;
  logic [2:0] addr_n;
  logic [15:0] data_n;
  assign start   = (state == IDLE) && |req;
  assign abort_g = |(abort & grant);
  assign done    = (state == DONE) ? grant : '0;
  assign aborted = (state == DONE) && ab_flag;
  assign busy    = |grant;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk), .reset(reset), .req(req), .advance(start), .winner(winner)
  );
  always_comb begin
    sel_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) if (winner[i]) sel_delay = delay[32*i +: 32];
    clamped = (sel_delay < 32'(MIN_DELAY)) ? 32'(MIN_DELAY) : sel_delay;
  end
  always_comb begin
    state_n = state;
    ab_n    = ab_flag;
    case (state)
      IDLE:     begin state_n = start ? WR_STOP : IDLE; ab_n = 1'b0; end
      WR_STOP:  state_n = WR_PERL;
      WR_PERL:  state_n = WR_PERH;
      WR_PERH:  state_n = WR_CLR0;
      WR_CLR0:  state_n = WR_START;
      WR_START: state_n = WAIT_IRQ;
      WAIT_IRQ: state_n = tmr_irq ? WR_CLR1 : WAIT_IRQ;
      WR_CLR1:  state_n = WR_HALT;
      WR_HALT:  state_n = DONE;
      default:  state_n = IDLE;
    endcase
    // a same-cycle timeout beats the cancel, so the completion reports as normal
    if (state inside {WR_PERL, WR_PERH, WR_CLR0, WR_START, WAIT_IRQ} && abort_g &&
        !(state == WAIT_IRQ && tmr_irq)) begin
      state_n = WR_CLR1;
      ab_n    = 1'b1;
    end
  end
  always_comb begin
    addr_n = '0;
    data_n = '0;
    case (state_n)
      WR_STOP:  begin addr_n = TMR_CONTROL; data_n = CMD_STOP; end
      WR_PERL:  begin addr_n = TMR_PERIODL; data_n = period[15:0]; end
      WR_PERH:  begin addr_n = TMR_PERIODH; data_n = period[31:16]; end
      WR_CLR0:  addr_n = TMR_STATUS;
      WR_START: begin addr_n = TMR_CONTROL; data_n = CMD_START; end
      WR_CLR1:  addr_n = TMR_STATUS;
      WR_HALT:  begin addr_n = TMR_CONTROL; data_n = ab_n ? CMD_STOP : 16'h0; end
      default:  ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ab_flag        <= 1'b0;
      period         <= '0;
      grant          <= '0;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
    end else begin
      state          <= state_n;
      ab_flag        <= ab_n;
      tmr_address    <= addr_n;
      tmr_writedata  <= data_n;
      tmr_chipselect <= is_wr(state_n);
      tmr_write_n    <= !is_wr(state_n);
      if (start) begin
        grant  <= winner;
        period <= clamped - 32'd1;
      end else if (state == DONE) grant <= '0;
    end
  end
endmodule
